// File: rtl/adder_vector_checker.sv
// Self-test sequencer for an external adder: drives LFSR-derived operands, waits for
// the adder to settle, checks the returned sum and records the first failing vector.
//
// state | meaning
// IDLE  | waiting for start
// APPLY | operands driven, settle counter running
// CHECK | sum sampled and compared on the edge leaving this state
// DONE  | run finished, results held until start or reset
module adder_vector_checker #(
    parameter int WIDTH  = 8,
    parameter int NVEC   = 64,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             cin,
    input  logic [WIDTH-1:0] s,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             err_pulse,
    output logic [15:0]      errors,
    output logic [15:0]      vectornum,
    output logic             fail_valid,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic [WIDTH-1:0] fail_s,
    output logic             fail_cin
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] APPLY = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [15:0] SEED        = 16'hACE1;
    localparam logic [15:0] LAST_VEC    = 16'(NVEC - 1);
    localparam logic [3:0]  SETTLE_LOAD = 4'(SETTLE - 1);

    logic [1:0]       state;
    logic [15:0]      lfsr;
    logic [15:0]      lfsr_next;
    logic [15:0]      lfsr_load;
    logic [3:0]       settle_cnt;
    logic [WIDTH-1:0] a_src;
    logic [WIDTH-1:0] b_src;
    logic [WIDTH-1:0] sum_exp;

    assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    // CHECK loads the next vector; IDLE/DONE restart from the seed.
    assign lfsr_load = (state == CHECK) ? lfsr_next : SEED;

    generate
        if (WIDTH == 8) begin : g_w8
            assign a_src = lfsr_load[15:8];
            assign b_src = lfsr_load[7:0];
        end else begin : g_w16
            assign a_src = lfsr_load;
            assign b_src = {lfsr_load[7:0], lfsr_load[15:8]};
        end
    endgenerate

    assign sum_exp = a + b + {{(WIDTH-1){1'b0}}, cin};

    assign busy = (state == APPLY) || (state == CHECK);
    assign done = (state == DONE);
    assign pass = (state == DONE) && (errors == 16'h0000);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            lfsr       <= SEED;
            settle_cnt <= 4'd0;
            a          <= '0;
            b          <= '0;
            cin        <= 1'b0;
            err_pulse  <= 1'b0;
            errors     <= 16'h0000;
            vectornum  <= 16'h0000;
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_s     <= '0;
            fail_cin   <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        errors     <= 16'h0000;
                        vectornum  <= 16'h0000;
                        fail_valid <= 1'b0;
                        fail_a     <= '0;
                        fail_b     <= '0;
                        fail_s     <= '0;
                        fail_cin   <= 1'b0;
                        lfsr       <= SEED;
                        a          <= a_src;
                        b          <= b_src;
                        cin        <= 1'b0;
                        settle_cnt <= SETTLE_LOAD;
                        state      <= APPLY;
                    end
                end
                APPLY: begin
                    if (settle_cnt == 4'd0) state <= CHECK;
                    else settle_cnt <= settle_cnt - 4'd1;
                end
                CHECK: begin
                    // Else-branch form so an unknown sum is treated as a mismatch.
                    if (s == sum_exp) begin
                        err_pulse <= 1'b0;
                    end else begin
                        err_pulse <= 1'b1;
                        if (errors != 16'hFFFF) errors <= errors + 16'd1;
                        if (!fail_valid) begin
                            fail_valid <= 1'b1;
                            fail_a     <= a;
                            fail_b     <= b;
                            fail_s     <= s;
                            fail_cin   <= cin;
                        end
                    end
                    if (vectornum == LAST_VEC) begin
                        state <= DONE;
                    end else begin
                        lfsr       <= lfsr_next;
                        a          <= a_src;
                        b          <= b_src;
                        vectornum  <= vectornum + 16'd1;
                        cin        <= ~vectornum[0];
                        settle_cnt <= SETTLE_LOAD;
                        state      <= APPLY;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
